// File: rtl/median_filter_ctrl.sv
// Stream-side controller for the systolic median filter cell array.
// Accepts samples over valid/ready, drives them onto the array X bus with a
// shift strobe, selects the median cell one-hot and returns one median per
// sample once the window is full.
//
// Ports:
//   clk, reset        clock, asynchronous active-low reset
//   restart           1-cycle pulse: reload W and flush the array
//   W                 requested window size (sampled in INIT, clamped 1..WMAX)
//   in_valid/in_ready/in_data     upstream sample handshake
//   X, shift_en, arr_clear        array sample bus, advance strobe, clear
//   isMedian, R_median            one-hot median select, median read-back bus
//   out_valid/out_ready/out_data  downstream median handshake
//   w_active, filling             window in use, window not yet full
module median_filter_ctrl #(
  parameter int unsigned DATA_LENGTH = 32,
  parameter int unsigned WMAX        = 15,
  parameter int unsigned LOG_WMAX    = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   restart,
  input  logic [LOG_WMAX-1:0]    W,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_LENGTH-1:0] in_data,
  output logic [DATA_LENGTH-1:0] X,
  output logic                   shift_en,
  output logic                   arr_clear,
  output logic [WMAX-1:0]        isMedian,
  input  logic [DATA_LENGTH-1:0] R_median,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_LENGTH-1:0] out_data,
  output logic [LOG_WMAX-1:0]    w_active,
  output logic                   filling
);

  localparam int unsigned IDX_W = LOG_WMAX + 1;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_FILL = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  state_t                 state_q, state_n;
  logic [LOG_WMAX-1:0]    w_q, w_n;
  logic [LOG_WMAX-1:0]    fill_cnt, fill_n;
  logic                   cap_pending, cap_n;
  logic                   ov_n;
  logic [DATA_LENGTH-1:0] od_n;
  logic [LOG_WMAX-1:0]    w_clamp;
  logic [LOG_WMAX-1:0]    fill_inc;
  logic [IDX_W-1:0]       med_idx;
  logic                   capture;

  // Samples pass straight through to the array bus.
  assign X        = in_data;
  assign w_active = w_q;
  assign filling  = (state_q == ST_FILL);

  // Requested window clamped to 1..WMAX.
  always_comb begin
    w_clamp = W;
    if (W == '0) begin
      w_clamp = LOG_WMAX'(1);
    end else if (32'(W) > WMAX) begin
      w_clamp = LOG_WMAX'(WMAX);
    end
  end

  // Upper median for even windows, true median for odd.
  assign med_idx  = (IDX_W'(w_q) + IDX_W'(1)) >> 1;
  assign fill_inc = fill_cnt + LOG_WMAX'(1);

  // State register and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_INIT;
      w_q         <= LOG_WMAX'(1);
      fill_cnt    <= '0;
      cap_pending <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= '0;
    end else begin
      state_q     <= state_n;
      w_q         <= w_n;
      fill_cnt    <= fill_n;
      cap_pending <= cap_n;
      out_valid   <= ov_n;
      out_data    <= od_n;
    end
  end

  // Next-state, handshake and capture logic.
  always_comb begin
    state_n   = state_q;
    w_n       = w_q;
    fill_n    = fill_cnt;
    cap_n     = cap_pending;
    ov_n      = out_valid;
    od_n      = out_data;
    in_ready  = 1'b0;
    shift_en  = 1'b0;
    arr_clear = 1'b0;
    isMedian  = '0;
    // R_median reflects the previous shift, so it can be captured at the
    // same edge that shifts in the next sample.
    capture   = cap_pending && (!out_valid || out_ready);

    case (state_q)
      ST_INIT: begin
        arr_clear = 1'b1;
        w_n       = w_clamp;
        fill_n    = '0;
        cap_n     = 1'b0;
        ov_n      = 1'b0;
        state_n   = ST_FILL;
      end
      ST_FILL, ST_RUN: begin
        isMedian = WMAX'(1) << (med_idx - IDX_W'(1));
        in_ready = !restart && (!cap_pending || !out_valid || out_ready);
        shift_en = in_valid && in_ready;

        if (capture) begin
          od_n  = R_median;
          ov_n  = 1'b1;
          cap_n = 1'b0;
        end else if (out_ready) begin
          ov_n = 1'b0;
        end

        // A new accept re-arms capture even when one completes this edge.
        if (shift_en) begin
          if (state_q == ST_FILL) begin
            if (fill_inc == w_q) begin
              fill_n  = w_q;
              cap_n   = 1'b1;
              state_n = ST_RUN;
            end else begin
              fill_n = fill_inc;
            end
          end else begin
            cap_n = 1'b1;
          end
        end
      end
      default: begin
        state_n = ST_INIT;
      end
    endcase

    // Restart flushes everything, including a pending or held median.
    if (restart) begin
      state_n = ST_INIT;
      fill_n  = '0;
      cap_n   = 1'b0;
      ov_n    = 1'b0;
    end
  end

endmodule

// File: tb/tb_median_filter_ctrl.sv
// Self-checking bench for median_filter_ctrl: a behavioural cell-array model
// drives R_median, and a sliding-window scoreboard checks every median.
module tb_median_filter_ctrl;

  localparam int unsigned DL   = 32;
  localparam int unsigned WMAX = 15;
  localparam int unsigned LW   = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            restart = 1'b0;
  logic [LW-1:0]   W = 4'd3;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [DL-1:0]   in_data = '0;
  logic [DL-1:0]   X;
  logic            shift_en;
  logic            arr_clear;
  logic [WMAX-1:0] isMedian;
  logic [DL-1:0]   R_median;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [DL-1:0]   out_data;
  logic [LW-1:0]   w_active;
  logic            filling;

  int vectors = 0;
  int miscompares = 0;
  int cur_w = 3;

  logic [DL-1:0] acc_q[$];
  logic [DL-1:0] exp_q[$];
  logic [DL-1:0] got_q[$];
  logic [WMAX-1:0][DL-1:0] hist;
  logic          prev_stall = 1'b0;
  logic [DL-1:0] prev_data = '0;

  median_filter_ctrl #(.DATA_LENGTH(DL), .WMAX(WMAX), .LOG_WMAX(LW)) dut (
    .clk(clk), .reset(reset), .restart(restart), .W(W),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .X(X), .shift_en(shift_en), .arr_clear(arr_clear),
    .isMedian(isMedian), .R_median(R_median),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .w_active(w_active), .filling(filling)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int clampw(input logic [LW-1:0] w);
    if (w == 0) return 1;
    if (int'(w) > int'(WMAX)) return int'(WMAX);
    return int'(w);
  endfunction

  // Reference: upper median = element w/2 of the ascending-sorted window.
  function automatic logic [DL-1:0] ref_median(input logic [DL-1:0] q[$], input int w);
    logic [DL-1:0] win[$];
    for (int i = q.size() - w; i < q.size(); i++) win.push_back(q[i]);
    win.sort();
    return win[w/2];
  endfunction

  // Cell array model: cells hold the window sorted largest-first, cell k
  // (bit k-1 of isMedian) drives the bus; no or multiple selects give junk.
  function automatic logic [DL-1:0] array_out(input logic [WMAX-1:0][DL-1:0] h,
                                              input int w, input logic [WMAX-1:0] sel);
    logic [DL-1:0] c[WMAX];
    logic [DL-1:0] t;
    logic [DL-1:0] v;
    int n;
    v = '0;
    n = 0;
    for (int i = 0; i < int'(WMAX); i++) c[i] = (i < w) ? h[i] : '0;
    for (int i = 0; i < w; i++)
      for (int j = 0; j < w - 1; j++)
        if (c[j] < c[j+1]) begin
          t = c[j]; c[j] = c[j+1]; c[j+1] = t;
        end
    for (int k = 0; k < int'(WMAX); k++)
      if (sel[k]) begin
        v = v | c[k];
        n++;
      end
    return (n == 1) ? v : 32'hDEAD_BEEF;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset)          hist <= '0;
    else if (arr_clear)  hist <= '0;
    else if (shift_en)   hist <= {hist[WMAX-2:0], X};
  end

  always_comb R_median = array_out(hist, cur_w, isMedian);

  // Scoreboard, sampled mid-cycle with the values the next edge will see.
  always @(negedge clk) begin
    if (!reset) begin
      acc_q.delete();
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_hold_valid", out_valid, 1);
        chk("stall_hold_data", out_data, prev_data);
      end
      prev_stall = out_valid && !out_ready && !restart;
      prev_data  = out_data;
      if (out_valid && out_ready) begin
        got_q.push_back(out_data);
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $error("FAIL unexpected_out: observed 0x%0h expected none", out_data);
        end else begin
          logic [DL-1:0] e;
          e = exp_q.pop_front();
          assert (out_data === e) else begin
            miscompares++;
            $error("FAIL median: observed 0x%0h expected 0x%0h", out_data, e);
          end
        end
      end
      if (restart) begin
        acc_q.delete();
        exp_q.delete();
      end else if (shift_en) begin
        acc_q.push_back(in_data);
        if (acc_q.size() > int'(WMAX)) void'(acc_q.pop_front());
        if (acc_q.size() >= cur_w) exp_q.push_back(ref_median(acc_q, cur_w));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DL-1:0] d);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      vectors++;
      miscompares++;
      $error("FAIL send_timeout: observed in_ready=0 expected 1 within 200 cycles");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic restart_to(input logic [LW-1:0] w);
    W        = w;
    cur_w    = clampw(w);
    in_valid = 1'b0;
    restart  = 1'b1;
    step();
    restart = 1'b0;
    @(negedge clk);
    chk("init_arr_clear", arr_clear, 1);
    chk("init_in_ready", in_ready, 0);
    chk("init_isMedian", isMedian, 0);
    step();
    chk("fill_filling", filling, 1);
    chk("fill_w_active", w_active, cur_w);
    chk("fill_isMedian", isMedian, 64'(1) << ((cur_w + 1) / 2 - 1));
    chk("fill_out_valid", out_valid, 0);
  endtask

  initial begin
    logic [DL-1:0] sq[$];
    #1 reset = 1'b0;
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_shift_en", shift_en, 0);
    chk("rst_arr_clear", arr_clear, 1);
    chk("rst_isMedian", isMedian, 0);
    chk("rst_w_active", w_active, 1);
    chk("rst_filling", filling, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("post_rst_init_clear", arr_clear, 1);
    chk("post_rst_init_ready", in_ready, 0);
    step();
    chk("w3_w_active", w_active, 3);
    chk("w3_isMedian", isMedian, 15'h0002);

    // W=3 stream 5,1,4,2,9 -> 4,2,4
    got_q.delete();
    send(5); send(1); send(4);
    chk("lat_not_yet", out_valid, 0);
    chk("run_not_filling", filling, 0);
    step();
    chk("lat_valid", out_valid, 1);
    chk("lat_data", out_data, 4);
    send(2); send(9);
    repeat (3) step();
    chk("w3_count", got_q.size(), 3);
    if (got_q.size() == 3) begin
      chk("w3_o0", got_q[0], 4);
      chk("w3_o1", got_q[1], 2);
      chk("w3_o2", got_q[2], 4);
    end

    // Backpressure: first median held, one more accept, then stall
    restart_to(3);
    got_q.delete();
    out_ready = 1'b0;
    send(10); send(20); send(30);
    step();
    chk("bp_valid", out_valid, 1);
    chk("bp_data", out_data, 20);
    send(40);
    in_valid = 1'b1;
    in_data  = 50;
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_shift_en", shift_en, 0);
      chk("bp_held", out_data, 20);
    end
    step();
    out_ready = 1'b1;
    send(50);
    repeat (3) step();
    chk("bp_count", got_q.size(), 3);
    if (got_q.size() == 3) begin
      chk("bp_o0", got_q[0], 20);
      chk("bp_o1", got_q[1], 30);
      chk("bp_o2", got_q[2], 40);
    end

    // Window sizes and clamping
    restart_to(4);
    chk("w4_isMedian", isMedian, 15'h0002);
    restart_to(5);
    chk("w5_isMedian", isMedian, 15'h0004);
    restart_to(15);
    chk("w15_w_active", w_active, 15);
    chk("w15_isMedian", isMedian, 15'h0080);
    restart_to(0);
    chk("w0_w_active", w_active, 1);
    chk("w0_isMedian", isMedian, 15'h0001);
    got_q.delete();
    sq.delete();
    for (int i = 0; i < 4; i++) begin
      sq.push_back($urandom);
      send(sq[i]);
    end
    repeat (3) step();
    chk("w0_count", got_q.size(), 4);
    if (got_q.size() == 4)
      for (int i = 0; i < 4; i++) chk("w0_passthru", got_q[i], sq[i]);

    // Restart mid-RUN: only the new 5 samples count
    restart_to(5);
    for (int i = 0; i < 7; i++) send($urandom_range(0, 1000));
    restart_to(5);
    got_q.delete();
    sq.delete();
    for (int i = 0; i < 4; i++) begin
      sq.push_back($urandom_range(0, 1000));
      send(sq[i]);
    end
    repeat (3) step();
    chk("rs_no_early_out", got_q.size(), 0);
    chk("rs_valid_low", out_valid, 0);
    sq.push_back($urandom_range(0, 1000));
    send(sq[4]);
    repeat (3) step();
    chk("rs_count", got_q.size(), 1);
    if (got_q.size() == 1) chk("rs_median", got_q[0], ref_median(sq, 5));

    // Async reset with a pending capture and a held output
    restart_to(3);
    out_ready = 1'b0;
    send(7); send(8); send(9);
    step();
    send(6);
    chk("ar_pre_valid", out_valid, 1);
    #2 reset = 1'b0;
    #1;
    chk("ar_out_valid", out_valid, 0);
    chk("ar_in_ready", in_ready, 0);
    chk("ar_arr_clear", arr_clear, 1);
    chk("ar_out_data", out_data, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("ar_init_clear", arr_clear, 1);
    chk("ar_init_ready", in_ready, 0);
    chk("ar_init_filling", filling, 0);
    step();
    chk("ar_fill", filling, 1);
    chk("ar_w_active", w_active, 3);

    // Random stream, random backpressure, random window
    for (int r = 0; r < 6; r++) begin
      restart_to(LW'($urandom_range(0, 15)));
      for (int c = 0; c < 80; c++) begin
        in_valid  = 1'($urandom_range(0, 1));
        in_data   = $urandom;
        out_ready = ($urandom_range(0, 3) != 0);
        step();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (4) step();
      chk("rand_drained", exp_q.size(), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish expected finish before 500us");
    $fatal(1, "watchdog expired");
  end

endmodule
